// File: rtl/mem_ack_responder_pkg.sv
// Shared types and constants for the fetch/memory-stage memory acknowledge responder.
package mem_ack_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DACC   = 2'b01,
        IFETCH = 2'b10
    } resp_state_e;

    // Hazard signalling towards the pipeline: an ack of 0 stalls the requesting stage.
    localparam logic ACK_STALL = 1'b0;
    localparam logic ACK_GO    = 1'b1;

endpackage

// File: rtl/mem_ack_responder_if.sv
// Pipeline request/ack signals and backing-memory request signals of the responder.
interface mem_ack_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ireqF;
    logic [AW-1:0] iaddrF;
    logic          instrackF;
    logic [DW-1:0] instrdataF;

    logic          dreadM;
    logic          dwriteM;
    logic [AW-1:0] daddrM;
    logic [DW-1:0] dwdataM;
    logic          dataackM;
    logic [DW-1:0] drdataM;

    logic          memreq;
    logic          memwrite;
    logic [AW-1:0] memaddr;
    logic [DW-1:0] memwdata;
    logic [DW-1:0] memrdata;
    logic          memready;

    modport slave (
        input  ireqF, iaddrF, dreadM, dwriteM, daddrM, dwdataM, memrdata, memready,
        output instrackF, instrdataF, dataackM, drdataM, memreq, memwrite, memaddr, memwdata
    );

    modport master (
        output ireqF, iaddrF, dreadM, dwriteM, daddrM, dwdataM, memrdata, memready,
        input  instrackF, instrdataF, dataackM, drdataM, memreq, memwrite, memaddr, memwdata
    );

endinterface

// File: rtl/mem_ack_responder_ifetch_line_buf.sv
// One-entry instruction line buffer: filled by completed fetches, dropped by matching writes.
module ifetch_line_buf
    import mem_ack_responder_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [AW-1:0] load_tag_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          inval_i,
    input  logic [AW-1:0] inval_addr_i,
    input  logic          lookup_i,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [DW-1:0] hit_data_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;

    // Fill and invalidate come from different access types, so they never collide.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            tag_d   = load_tag_i;
            data_d  = load_data_i;
        end else if (inval_i && (inval_addr_i == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o      = lookup_i && valid_q && (tag_q == lookup_addr_i);
    assign hit_data_o = data_q;

endmodule

// File: rtl/mem_ack_responder.sv
// Serialises fetch-stage instruction reads and memory-stage data accesses onto one
// backing-memory port, with a one-entry instruction buffer in front of the fetch path.
module mem_ack_responder
    import mem_ack_responder_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_ack_responder_if.slave bus
);

    resp_state_e   state_q, state_d;
    logic          memreq_q, memreq_d;
    logic          memwrite_q, memwrite_d;
    logic [AW-1:0] memaddr_q, memaddr_d;
    logic [DW-1:0] memwdata_q, memwdata_d;

    logic          dataReq;
    logic          dataDone;
    logic          fetchDone;
    logic          fetchDeliver;
    logic          bufHit;
    logic [DW-1:0] bufData;

    assign dataReq   = bus.dreadM | bus.dwriteM;
    assign dataDone  = (state_q == DACC) && bus.memready;
    assign fetchDone = (state_q == IFETCH) && bus.memready;
    // A fetch result is only handed to the pipeline if it is still asking for that line.
    assign fetchDeliver = fetchDone && bus.ireqF && (bus.iaddrF == memaddr_q);

    ifetch_line_buf #(.AW(AW), .DW(DW)) u_line_buf (
        .clk           (clk),
        .reset         (reset),
        .load_i        (fetchDone),
        .load_tag_i    (memaddr_q),
        .load_data_i   (bus.memrdata),
        .inval_i       (dataDone && memwrite_q),
        .inval_addr_i  (memaddr_q),
        .lookup_i      (bus.ireqF),
        .lookup_addr_i (bus.iaddrF),
        .hit_o         (bufHit),
        .hit_data_o    (bufData)
    );

    always_comb begin
        state_d    = state_q;
        memreq_d   = memreq_q;
        memwrite_d = memwrite_q;
        memaddr_d  = memaddr_q;
        memwdata_d = memwdata_q;
        unique case (state_q)
            IDLE: begin
                if (dataReq) begin
                    state_d    = DACC;
                    memreq_d   = 1'b1;
                    memwrite_d = bus.dwriteM;
                    memaddr_d  = bus.daddrM;
                    memwdata_d = bus.dwdataM;
                end else if (bus.ireqF && !bufHit) begin
                    state_d    = IFETCH;
                    memreq_d   = 1'b1;
                    memwrite_d = 1'b0;
                    memaddr_d  = bus.iaddrF;
                    memwdata_d = '0;
                end
            end
            DACC, IFETCH: begin
                if (bus.memready) begin
                    state_d  = IDLE;
                    memreq_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                memreq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            memreq_q   <= 1'b0;
            memwrite_q <= 1'b0;
            memaddr_q  <= '0;
            memwdata_q <= '0;
        end else begin
            state_q    <= state_d;
            memreq_q   <= memreq_d;
            memwrite_q <= memwrite_d;
            memaddr_q  <= memaddr_d;
            memwdata_q <= memwdata_d;
        end
    end

    // Buffer hits are answered in any state; otherwise a present request stalls until its completion.
    always_comb begin
        bus.dataackM   = dataReq ? ACK_STALL : ACK_GO;
        bus.drdataM    = '0;
        bus.instrackF  = bus.ireqF ? ACK_STALL : ACK_GO;
        bus.instrdataF = '0;
        if (dataDone) begin
            bus.dataackM = ACK_GO;
            bus.drdataM  = bus.memrdata;
        end
        if (bufHit) begin
            bus.instrackF  = ACK_GO;
            bus.instrdataF = bufData;
        end else if (fetchDeliver) begin
            bus.instrackF  = ACK_GO;
            bus.instrdataF = bus.memrdata;
        end
    end

    assign bus.memreq   = memreq_q;
    assign bus.memwrite = memwrite_q;
    assign bus.memaddr  = memaddr_q;
    assign bus.memwdata = memwdata_q;

endmodule
